cpu_step_master: RTL and testbench
==================================

# cpu_step_master

Debug-link command sequencer that drives the CPU clock controller's step/reset request interface. Accepts decoded command bytes from the UART receive path and converts them into `ctl_rst`/`ctl_step` requests with a `ctl_busy` handshake. Runs single or counted step bursts, guards each request with a timeout, and returns one status byte per command to the UART transmit path.

## Interface
- `TIMEOUT`, default 1024: cycles allowed for each busy phase (busy rise, busy fall) before abort.
- `TO_W`, default 11: timeout counter width; must satisfy 2^TO_W > TIMEOUT.
- `clk_in  in  1`: system clock, also the clock of the clock controller.
- `rst_n  in  1`: reset, synchronous, active-low, sampled on posedge `clk_in`.
- `cmd_valid  in  1`: command byte available.
- `cmd_data  in  8`: command byte.
- `cmd_ready  out  1`: byte consumed on the cycle where `cmd_valid & cmd_ready` is true.
- `resp_valid  out  1`: status byte pending.
- `resp_data  out  8`: status byte.
- `resp_ready  in  1`: transmitter accepts the status byte.
- `ctl_stepmode  out  1`: 1 = CPU clock gated (step mode).
- `ctl_rst  out  1`: reset request level.
- `ctl_step  out  1`: step request level.
- `ctl_busy  in  1`: controller busy.

## Operation
- Command bytes:
  - `0x48` 'H': set stepmode = 1, respond 'K' (0x4B).
  - `0x47` 'G': set stepmode = 0, respond 'K'.
  - `0x52` 'R': one reset request, respond 'K'.
  - `0x53` 'S': one step, respond 'K'.
  - `0x4E` 'N': the next byte is the step count n; 0 means 256. Issue n steps, respond 'K'.
  - Any other byte: respond '?' (0x3F).
- 'S' or 'N' while stepmode = 0: respond 'E' (0x45). No request is issued. The count byte after 'N' is still consumed.
- 'R' is allowed in either mode.
- State machine:
  - IDLE: `cmd_ready` = 1. Decode the accepted byte. Go to GET_CNT ('N'), ISSUE ('R', 'S'), or RESP (all other bytes).
  - GET_CNT: `cmd_ready` = 1. Load the 9-bit remaining counter: `{cmd_data == 0, cmd_data}`. Then go to ISSUE, or to RESP with 'E'.
  - ISSUE: hold `ctl_rst` or `ctl_step` at 1 until `ctl_busy` = 1 is sampled. Then drop the request in the same cycle and go to WAIT_DONE.
  - WAIT_DONE: wait for `ctl_busy` = 0.
    - Reset command: go to RESP with 'K'.
    - Step command: decrement remaining. If the result is nonzero, go back to ISSUE. Otherwise go to RESP with 'K'.
  - RESP: hold `resp_valid` = 1 and `resp_data` stable until `resp_ready` = 1. Then go to IDLE.
- Timeout:
  - The counter clears on entry to ISSUE and to WAIT_DONE, and increments in both states.
  - On reaching TIMEOUT: deassert the request and go to RESP with 'T' (0x54). Any remaining steps are discarded.
- `cmd_ready` = 0 in ISSUE, WAIT_DONE and RESP. Bytes arriving then are back-pressured, not dropped.
- `ctl_rst` and `ctl_step` are never both 1.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `ctl_stepmode` 0, `ctl_rst` 0, `ctl_step` 0, `resp_valid` 0, `resp_data` 0x00, `cmd_ready` 1, counters 0.
- Reset mid-operation drops any request on the next edge. A pending response is lost.
- Request rises on the cycle after the command byte is accepted.
- Controller response: busy is seen one cycle after the request; the request falls on the following edge.
- Reset phase is 4 cycles from accept to `resp_valid`: accept, request, busy high, busy low.
- 'H'/'G': `resp_valid` rises 1 cycle after accept. The `ctl_stepmode` change becomes visible in the same cycle.
- Counted steps repeat back-to-back with no idle gap: WAIT_DONE exit is followed immediately by ISSUE.
- `ctl_busy` already high on ISSUE entry counts as an acknowledge.

## Structure
- Shared debug-link package holds:
  - command byte constants: CMD_HALT, CMD_GO, CMD_RST, CMD_STEP, CMD_NSTEP;
  - response constants: RSP_OK, RSP_ERR, RSP_BADCMD, RSP_TIMEOUT;
  - the state encoding.
- One sub-module is natural: `busy_timeout`, a clearable up-counter with an `expired` flag, parameterised by TIMEOUT/TO_W.

## Test plan
- Reset check: after reset, with 'R' issued against the real clock controller, `ctl_rst` pulses and the response is 0x4B; all outputs match their reset values beforehand.
- 'S' with stepmode 0 -> no `ctl_step` pulse, response 0x45. Then 'H' followed by 'S' -> exactly one step handshake, response 0x4B.
- 'H', 'N', 0x03 against a controller model whose `cpu_step` arrives 5 cycles after busy -> exactly 3 busy rise/fall cycles, a single 0x4B after the third.
- 'N', 0x00 -> 256 steps counted, then 0x4B.
- `ctl_busy` held 0 (stub) with 'H','S' -> `ctl_step` deasserts after 1024 cycles, response 0x54. Holding busy at 1 -> 0x54 after the WAIT_DONE timeout.
- `resp_ready` held low 20 cycles with bytes queued on `cmd_valid` -> `resp_data` stable, `cmd_ready` = 0, no byte lost. Separately, `rst_n` low during a step burst -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/cpu_step_master_pkg.sv
// Shared debug-link definitions: command bytes, status bytes and the
// sequencer state encoding.
package cpu_step_master_pkg;

   localparam logic [7:0] CMD_HALT  = 8'h48;
   localparam logic [7:0] CMD_GO    = 8'h47;
   localparam logic [7:0] CMD_RST   = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_NSTEP = 8'h4E;

   localparam logic [7:0] RSP_OK      = 8'h4B;
   localparam logic [7:0] RSP_ERR     = 8'h45;
   localparam logic [7:0] RSP_BADCMD  = 8'h3F;
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_CNT   = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } state_e;

endpackage

// File: rtl/cpu_step_master_busy_timeout.sv
// Clearable cycle counter guarding one busy phase; expired is high on the
// TIMEOUT-th cycle spent in the phase.
module cpu_step_master_busy_timeout #(
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] count_q;
   logic [TO_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = en && (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_step_master.sv
// Debug-link command sequencer: turns command bytes into step/reset requests
// on the clock controller handshake and returns one status byte per command.
module cpu_step_master
   import cpu_step_master_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       resp_valid,
   output logic [7:0] resp_data,
   input  logic       resp_ready,
   output logic       ctl_stepmode,
   output logic       ctl_rst,
   output logic       ctl_step,
   input  logic       ctl_busy
);

   state_e     state_q, state_d;
   logic       stepmode_q, stepmode_d;
   logic       ctl_rst_q, ctl_rst_d;
   logic       ctl_step_q, ctl_step_d;
   logic       resp_valid_q, resp_valid_d;
   logic [7:0] resp_data_q, resp_data_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       is_rst_q, is_rst_d;
   logic [8:0] remaining_q, remaining_d;

   logic       cmd_accept;
   logic       go_resp;
   logic [7:0] rsp_code;
   logic [8:0] rem_dec;
   logic       to_clr;
   logic       to_en;
   logic       to_expired;

   assign cmd_accept = cmd_valid && cmd_ready_q;
   assign rem_dec    = remaining_q - 9'd1;

   always_comb begin
      state_d      = state_q;
      stepmode_d   = stepmode_q;
      ctl_rst_d    = ctl_rst_q;
      ctl_step_d   = ctl_step_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      is_rst_d     = is_rst_q;
      remaining_d  = remaining_q;
      go_resp      = 1'b0;
      rsp_code     = RSP_OK;

      case (state_q)
         ST_IDLE: begin
            if (cmd_accept) begin
               case (cmd_data)
                  CMD_HALT: begin
                     stepmode_d = 1'b1;
                     go_resp    = 1'b1;
                  end
                  CMD_GO: begin
                     stepmode_d = 1'b0;
                     go_resp    = 1'b1;
                  end
                  CMD_RST: begin
                     is_rst_d  = 1'b1;
                     ctl_rst_d = 1'b1;
                     state_d   = ST_ISSUE;
                  end
                  CMD_STEP: begin
                     if (stepmode_q) begin
                        is_rst_d    = 1'b0;
                        remaining_d = 9'd1;
                        ctl_step_d  = 1'b1;
                        state_d     = ST_ISSUE;
                     end else begin
                        go_resp  = 1'b1;
                        rsp_code = RSP_ERR;
                     end
                  end
                  CMD_NSTEP: state_d = ST_GET_CNT;
                  default: begin
                     go_resp  = 1'b1;
                     rsp_code = RSP_BADCMD;
                  end
               endcase
            end
         end

         // A count byte of zero loads 256 through the extra top bit.
         ST_GET_CNT: begin
            if (cmd_accept) begin
               if (stepmode_q) begin
                  is_rst_d    = 1'b0;
                  remaining_d = {cmd_data == 8'h00, cmd_data};
                  ctl_step_d  = 1'b1;
                  state_d     = ST_ISSUE;
               end else begin
                  go_resp  = 1'b1;
                  rsp_code = RSP_ERR;
               end
            end
         end

         ST_ISSUE: begin
            if (ctl_busy) begin
               ctl_rst_d  = 1'b0;
               ctl_step_d = 1'b0;
               state_d    = ST_WAIT_DONE;
            end else if (to_expired) begin
               ctl_rst_d  = 1'b0;
               ctl_step_d = 1'b0;
               go_resp    = 1'b1;
               rsp_code   = RSP_TIMEOUT;
            end
         end

         ST_WAIT_DONE: begin
            if (!ctl_busy) begin
               if (is_rst_q) begin
                  go_resp = 1'b1;
               end else begin
                  remaining_d = rem_dec;
                  if (rem_dec != 9'd0) begin
                     ctl_step_d = 1'b1;
                     state_d    = ST_ISSUE;
                  end else begin
                     go_resp = 1'b1;
                  end
               end
            end else if (to_expired) begin
               remaining_d = 9'd0;
               go_resp     = 1'b1;
               rsp_code    = RSP_TIMEOUT;
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (go_resp) begin
         state_d      = ST_RESP;
         resp_valid_d = 1'b1;
         resp_data_d  = rsp_code;
      end

      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_CNT);
   end

   // Every state change restarts the phase timer; only ISSUE/WAIT_DONE use it.
   assign to_clr = (state_d != state_q);
   assign to_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);

   cpu_step_master_busy_timeout #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_busy_timeout (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         stepmode_q   <= 1'b0;
         ctl_rst_q    <= 1'b0;
         ctl_step_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 8'h00;
         cmd_ready_q  <= 1'b1;
         is_rst_q     <= 1'b0;
         remaining_q  <= 9'd0;
      end else begin
         state_q      <= state_d;
         stepmode_q   <= stepmode_d;
         ctl_rst_q    <= ctl_rst_d;
         ctl_step_q   <= ctl_step_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         cmd_ready_q  <= cmd_ready_d;
         is_rst_q     <= is_rst_d;
         remaining_q  <= remaining_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign ctl_stepmode = stepmode_q;
   assign ctl_rst      = ctl_rst_q;
   assign ctl_step     = ctl_step_q;

endmodule

// File: tb/tb_cpu_step_master.sv
// Directed bench for cpu_step_master with a small clock-controller model
// that can also be forced stuck-low or stuck-high on busy.
module tb_cpu_step_master;

   localparam int LIMIT = 5000;

   logic       clk_in = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_ready = 1'b0;
   logic       ctl_stepmode;
   logic       ctl_rst;
   logic       ctl_step;
   logic       ctl_busy;

   int n_vec = 0;
   int n_miss = 0;

   int   busy_mode = 0;
   int   hold_len = 0;
   logic bsy_q = 1'b0;
   int   hold_cnt = 0;

   int   n_step_rise = 0;
   int   n_rst_rise = 0;
   int   n_busy_rise = 0;
   int   n_busy_fall = 0;
   int   n_resp = 0;
   int   n_both = 0;
   logic step_prev = 1'b0;
   logic rst_prev = 1'b0;
   logic busy_prev = 1'b0;

   cpu_step_master #(
      .TIMEOUT (1024),
      .TO_W    (11)
   ) dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_data     (cmd_data),
      .cmd_ready    (cmd_ready),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_ready   (resp_ready),
      .ctl_stepmode (ctl_stepmode),
      .ctl_rst      (ctl_rst),
      .ctl_step     (ctl_step),
      .ctl_busy     (ctl_busy)
   );

   always #5 clk_in = ~clk_in;

   // Controller model: busy rises the cycle after a request, stays high
   // hold_len extra cycles, then falls.
   always @(posedge clk_in) begin
      if (!rst_n) begin
         bsy_q    <= 1'b0;
         hold_cnt <= 0;
      end else if (!bsy_q) begin
         if (ctl_rst || ctl_step) begin
            bsy_q    <= 1'b1;
            hold_cnt <= hold_len;
         end
      end else if (hold_cnt != 0) begin
         hold_cnt <= hold_cnt - 1;
      end else begin
         bsy_q <= 1'b0;
      end
   end

   assign ctl_busy = (busy_mode == 1) ? 1'b0 : (busy_mode == 2) ? 1'b1 : bsy_q;

   always @(posedge clk_in) begin
      if (ctl_step && !step_prev) n_step_rise = n_step_rise + 1;
      if (ctl_rst && !rst_prev) n_rst_rise = n_rst_rise + 1;
      if (ctl_busy && !busy_prev) n_busy_rise = n_busy_rise + 1;
      if (!ctl_busy && busy_prev) n_busy_fall = n_busy_fall + 1;
      if (resp_valid && resp_ready) n_resp = n_resp + 1;
      if (ctl_step && ctl_rst) n_both = n_both + 1;
      step_prev <= ctl_step;
      rst_prev  <= ctl_rst;
      busy_prev <= ctl_busy;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clk_in);
      cmd_valid = 1'b1;
      cmd_data  = b;
      while (!cmd_ready && t < LIMIT) begin
         @(negedge clk_in);
         t++;
      end
      chk("send_accept", 32'(t < LIMIT), 32'd1);
      @(posedge clk_in);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int t = 0;
      while (!resp_valid && t < LIMIT) begin
         @(negedge clk_in);
         t++;
      end
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
   endtask

   task automatic take_resp(input string tag, input logic [7:0] exp);
      wait_resp(tag);
      chk(tag, 32'(resp_data), 32'(exp));
      @(negedge clk_in);
      resp_ready = 1'b1;
      @(posedge clk_in);
      #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_step, b_rst, b_bsy, b_fall, b_resp, hi, bad_d, bad_r, bad_v;

      rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'h00);
      chk("rst_stepmode", 32'(ctl_stepmode), 32'd0);
      chk("rst_ctl_rst", 32'(ctl_rst), 32'd0);
      chk("rst_ctl_step", 32'(ctl_step), 32'd0);
      rst_n = 1'b1;
      @(negedge clk_in);

      // 'R': accept, request, busy high, busy low, then response
      b_rst = n_rst_rise;
      send_byte(8'h52);
      @(negedge clk_in);
      chk("r_req_c1", 32'(ctl_rst), 32'd1);
      chk("r_step_c1", 32'(ctl_step), 32'd0);
      @(negedge clk_in);
      chk("r_busy_c2", 32'(ctl_busy), 32'd1);
      @(negedge clk_in);
      chk("r_req_c3", 32'(ctl_rst), 32'd0);
      chk("r_valid_c3", 32'(resp_valid), 32'd0);
      @(negedge clk_in);
      chk("r_valid_c4", 32'(resp_valid), 32'd1);
      take_resp("r_resp", 8'h4B);
      chk("r_pulses", 32'(n_rst_rise - b_rst), 32'd1);

      // 'S' outside step mode
      b_step = n_step_rise;
      send_byte(8'h53);
      take_resp("s_nomode", 8'h45);
      chk("s_nomode_steps", 32'(n_step_rise - b_step), 32'd0);

      // 'H' then 'S'
      send_byte(8'h48);
      @(negedge clk_in);
      chk("h_valid_c1", 32'(resp_valid), 32'd1);
      chk("h_stepmode", 32'(ctl_stepmode), 32'd1);
      take_resp("h_resp", 8'h4B);
      b_step = n_step_rise;
      b_bsy  = n_busy_rise;
      send_byte(8'h53);
      take_resp("s_resp", 8'h4B);
      chk("s_steps", 32'(n_step_rise - b_step), 32'd1);
      chk("s_busy", 32'(n_busy_rise - b_bsy), 32'd1);

      // 'N' 3 with a slow controller
      hold_len = 5;
      b_step = n_step_rise;
      b_fall = n_busy_fall;
      b_resp = n_resp;
      send_byte(8'h4E);
      send_byte(8'h03);
      wait_resp("n3");
      chk("n3_busy_falls", 32'(n_busy_fall - b_fall), 32'd3);
      chk("n3_steps", 32'(n_step_rise - b_step), 32'd3);
      take_resp("n3_resp", 8'h4B);
      chk("n3_resp_count", 32'(n_resp - b_resp), 32'd1);
      hold_len = 0;
      repeat (3) @(negedge clk_in);

      // 'N' 0 means 256
      b_step = n_step_rise;
      send_byte(8'h4E);
      send_byte(8'h00);
      take_resp("n256_resp", 8'h4B);
      chk("n256_steps", 32'(n_step_rise - b_step), 32'd256);

      // 'N' outside step mode still eats the count byte
      send_byte(8'h47);
      take_resp("g_resp", 8'h4B);
      b_step = n_step_rise;
      send_byte(8'h4E);
      send_byte(8'h05);
      take_resp("n_nomode", 8'h45);
      chk("n_nomode_steps", 32'(n_step_rise - b_step), 32'd0);
      send_byte(8'h48);
      take_resp("h_after_cnt", 8'h4B);

      send_byte(8'h00);
      take_resp("bad_cmd", 8'h3F);

      // busy never rises: step request held 1024 cycles then dropped
      busy_mode = 1;
      send_byte(8'h53);
      hi = 0;
      repeat (1024) begin
         @(negedge clk_in);
         if (ctl_step) hi++;
      end
      chk("to_low_req_cycles", 32'(hi), 32'd1024);
      @(negedge clk_in);
      chk("to_low_req_drop", 32'(ctl_step), 32'd0);
      chk("to_low_valid", 32'(resp_valid), 32'd1);
      take_resp("to_low_resp", 8'h54);

      // busy never falls: times out in the done phase
      busy_mode = 2;
      send_byte(8'h53);
      take_resp("to_high_resp", 8'h54);
      chk("to_high_req", 32'(ctl_step), 32'd0);
      busy_mode = 0;
      repeat (3) @(negedge clk_in);

      // response back-pressure with a byte waiting
      send_byte(8'h48);
      @(negedge clk_in);
      cmd_valid = 1'b1;
      cmd_data  = 8'h47;
      bad_d = 0;
      bad_r = 0;
      bad_v = 0;
      repeat (20) begin
         @(negedge clk_in);
         if (resp_data !== 8'h4B) bad_d++;
         if (cmd_ready !== 1'b0) bad_r++;
         if (resp_valid !== 1'b1) bad_v++;
      end
      chk("bp_data_stable", 32'(bad_d), 32'd0);
      chk("bp_cmd_ready_low", 32'(bad_r), 32'd0);
      chk("bp_valid_held", 32'(bad_v), 32'd0);
      resp_ready = 1'b1;
      @(posedge clk_in);
      #1;
      resp_ready = 1'b0;
      send_byte(8'h47);
      take_resp("bp_g_resp", 8'h4B);
      chk("bp_g_stepmode", 32'(ctl_stepmode), 32'd0);

      // reset in the middle of a burst
      send_byte(8'h48);
      take_resp("mr_h", 8'h4B);
      hold_len = 5;
      send_byte(8'h4E);
      send_byte(8'h10);
      repeat (10) @(negedge clk_in);
      rst_n = 1'b0;
      @(posedge clk_in);
      #1;
      chk("mr_ctl_step", 32'(ctl_step), 32'd0);
      chk("mr_ctl_rst", 32'(ctl_rst), 32'd0);
      chk("mr_stepmode", 32'(ctl_stepmode), 32'd0);
      chk("mr_resp_valid", 32'(resp_valid), 32'd0);
      chk("mr_resp_data", 32'(resp_data), 32'h00);
      chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk_in);
      rst_n = 1'b1;
      hold_len = 0;
      repeat (20) @(negedge clk_in);
      chk("mr_no_resp", 32'(resp_valid), 32'd0);
      chk("mr_no_step", 32'(ctl_step), 32'd0);

      chk("never_both", 32'(n_both), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
